// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Per-stage control bundles are named constants so the FSM reads as a table.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_INIT_ENC     = 2'd0;
  localparam logic [1:0] ST_RUN_ENC      = 2'd1;
  localparam logic [1:0] ST_BUBBLE_ENC   = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT     = ST_INIT_ENC,
    ST_RUN      = ST_RUN_ENC,
    ST_BUBBLE   = ST_BUBBLE_ENC,
    ST_MEM_WAIT = ST_MEM_WAIT_ENC
  } state_e;

  // Instruction loaded into a pipeline register when it is flushed.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_redirect;
    logic ifid_en;
    logic ifid_flush;
    logic idexe_en;
    logic idexe_flush;
    logic exemem_en;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT = '{pc_en: 1'b0, pc_sel_redirect: 1'b0,
                                  ifid_en: 1'b0, ifid_flush: 1'b1,
                                  idexe_en: 1'b0, idexe_flush: 1'b1,
                                  exemem_en: 1'b0, memwb_flush: 1'b1};

  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, pc_sel_redirect: 1'b0,
                                 ifid_en: 1'b1, ifid_flush: 1'b0,
                                 idexe_en: 1'b1, idexe_flush: 1'b0,
                                 exemem_en: 1'b1, memwb_flush: 1'b0};

  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, pc_sel_redirect: 1'b0,
                                    ifid_en: 1'b0, ifid_flush: 1'b0,
                                    idexe_en: 1'b0, idexe_flush: 1'b0,
                                    exemem_en: 1'b0, memwb_flush: 1'b1};

  // A flushed register must still load its NOP, so each flush brings its enable.
  localparam ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, pc_sel_redirect: 1'b1,
                                      ifid_en: 1'b1, ifid_flush: 1'b1,
                                      idexe_en: 1'b1, idexe_flush: 1'b1,
                                      exemem_en: 1'b1, memwb_flush: 1'b0};

  localparam ctrl_t CTRL_LOAD_STALL = '{pc_en: 1'b0, pc_sel_redirect: 1'b0,
                                        ifid_en: 1'b0, ifid_flush: 1'b0,
                                        idexe_en: 1'b1, idexe_flush: 1'b1,
                                        exemem_en: 1'b1, memwb_flush: 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard requests in, per-stage enables/flushes out.
// PIPE_STALL_CTRL_PERF_EN adds the performance counter outputs.
interface pipe_stall_ctrl_if
`ifdef PIPE_STALL_CTRL_PERF_EN
  #(parameter int PERF_W = 32)
`endif
  ;
  logic load_hazard;
  logic redirect;
  logic dmem_busy;

  logic pc_en;
  logic pc_sel_redirect;
  logic ifid_en;
  logic ifid_flush;
  logic idexe_en;
  logic idexe_flush;
  logic exemem_en;
  logic memwb_flush;
  logic mem_timeout;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_load_stalls;
  logic [PERF_W-1:0] perf_mem_stalls;
  logic [PERF_W-1:0] perf_redirects;
`endif

  // Pipeline side: raises hazards, obeys controls.
  modport master (
    output load_hazard, redirect, dmem_busy,
`ifdef PIPE_STALL_CTRL_PERF_EN
    input  perf_load_stalls, perf_mem_stalls, perf_redirects,
`endif
    input  pc_en, pc_sel_redirect, ifid_en, ifid_flush, idexe_en,
           idexe_flush, exemem_en, memwb_flush, mem_timeout
  );

  // Scheduler side.
  modport slave (
    input  load_hazard, redirect, dmem_busy,
`ifdef PIPE_STALL_CTRL_PERF_EN
    output perf_load_stalls, perf_mem_stalls, perf_redirects,
`endif
    output pc_en, pc_sel_redirect, ifid_en, ifid_flush, idexe_en,
           idexe_flush, exemem_en, memwb_flush, mem_timeout
  );

endinterface

// File: rtl/pipe_wait_timer.sv
// Saturating memory-wait counter with a sticky timeout flag.
// The counter is cleared on any cycle the memory is not busy.
module pipe_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W:0]   cnt_inc;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    if (busy_i) begin
      cnt_d = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
      // Judged on the unsaturated count so MAX_WAIT = 2^CNT_W-1 still trips.
      if (int'(cnt_inc) > MAX_WAIT) timeout_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler merging load-use, redirect and data-memory wait hazards.
// Define PIPE_STALL_CTRL_PERF_EN to add the performance counters.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
`ifdef PIPE_STALL_CTRL_PERF_EN
  ,
  parameter int PERF_W   = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  ctrl_t  ctrl;
  logic   redirect_applied;
  logic   timeout;

  always_comb begin
    ctrl             = CTRL_RUN;
    state_d          = state_q;
    pend_d           = pend_q;
    redirect_applied = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        ctrl    = CTRL_INIT;
        state_d = ST_RUN;
      end
      ST_RUN, ST_BUBBLE: begin
        if (bus.dmem_busy) begin
          ctrl    = CTRL_FREEZE;
          pend_d  = bus.redirect;
          state_d = ST_MEM_WAIT;
        end else if (bus.redirect) begin
          ctrl             = CTRL_REDIRECT;
          redirect_applied = 1'b1;
          state_d          = ST_RUN;
        end else if (bus.load_hazard && state_q == ST_RUN) begin
          // BUBBLE ignores load_hazard: one bubble per load-use pair.
          ctrl    = CTRL_LOAD_STALL;
          state_d = ST_BUBBLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_busy) begin
          ctrl   = CTRL_FREEZE;
          pend_d = pend_q | bus.redirect;
        end else begin
          pend_d = 1'b0;
          if (pend_q || bus.redirect) begin
            ctrl             = CTRL_REDIRECT;
            redirect_applied = 1'b1;
            state_d          = ST_RUN;
          end else if (bus.load_hazard) begin
            ctrl    = CTRL_LOAD_STALL;
            state_d = ST_BUBBLE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        ctrl    = CTRL_INIT;
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  pipe_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .busy_i    (bus.dmem_busy && state_q != ST_INIT),
    .timeout_o (timeout)
  );

  assign bus.pc_en           = ctrl.pc_en;
  assign bus.pc_sel_redirect = ctrl.pc_sel_redirect;
  assign bus.ifid_en         = ctrl.ifid_en;
  assign bus.ifid_flush      = ctrl.ifid_flush;
  assign bus.idexe_en        = ctrl.idexe_en;
  assign bus.idexe_flush     = ctrl.idexe_flush;
  assign bus.exemem_en       = ctrl.exemem_en;
  assign bus.memwb_flush     = ctrl.memwb_flush;
  assign bus.mem_timeout     = timeout;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_load_q, perf_mem_q, perf_redir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_load_q  <= '0;
      perf_mem_q   <= '0;
      perf_redir_q <= '0;
    end else begin
      perf_load_q  <= perf_load_q + PERF_W'(state_d == ST_BUBBLE);
      perf_mem_q   <= perf_mem_q + PERF_W'(bus.dmem_busy && state_q != ST_INIT);
      perf_redir_q <= perf_redir_q + PERF_W'(redirect_applied);
    end
  end

  assign bus.perf_load_stalls = perf_load_q;
  assign bus.perf_mem_stalls  = perf_mem_q;
  assign bus.perf_redirects   = perf_redir_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed hazard scenarios followed by random traffic, each cycle compared
// against a behavioural model of the scheduling rules.
module tb_pipe_stall_ctrl;

  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what the pipeline remembers between cycles.
  bit m_init;    // first cycle after reset
  bit m_pend;    // redirect owed once memory is ready
  bit m_bubble;  // previous cycle stalled for load-use
  int m_run;     // length of the current busy run
  bit m_to;      // timeout seen since reset

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (pc_en,sel,ifid_en,ifid_fl,idexe_en,idexe_fl,exemem_en,memwb_fl,tmo)",
               tag, got, exp);
    end
  endtask

  function automatic logic [8:0] observed();
    return {bus.pc_en, bus.pc_sel_redirect, bus.ifid_en, bus.ifid_flush,
            bus.idexe_en, bus.idexe_flush, bus.exemem_en, bus.memwb_flush,
            bus.mem_timeout};
  endfunction

  function automatic logic [8:0] expected(input bit lh, input bit rd, input bit bz);
    logic [7:0] c;
    if (m_init)             c = 8'b0_0_0_1_0_1_0_1;  // all registers flushed, nothing advances
    else if (bz)            c = 8'b0_0_0_0_0_0_0_1;  // freeze, bubble into WB
    else if (rd || m_pend)  c = 8'b1_1_1_1_1_1_1_0;  // load target, kill IF/ID and ID/EXE
    else if (lh && !m_bubble) c = 8'b0_0_0_0_1_1_1_0; // hold IF/ID, insert one bubble
    else                    c = 8'b1_0_1_0_1_0_1_0;
    return {c, m_to};
  endfunction

  function automatic void model_update(input bit lh, input bit rd, input bit bz);
    if (m_init) begin
      m_init   = 1'b0;
      m_bubble = 1'b0;
    end else if (bz) begin
      m_run++;
      m_pend   = m_pend | rd;
      m_bubble = 1'b0;
    end else begin
      m_bubble = !(rd || m_pend) && lh && !m_bubble;
      m_pend   = 1'b0;
      m_run    = 0;
    end
    if (m_run > MAX_WAIT) m_to = 1'b1;
  endfunction

  task automatic step(input string tag, input bit lh, input bit rd, input bit bz);
    @(negedge clk);
    bus.load_hazard = lh;
    bus.redirect    = rd;
    bus.dmem_busy   = bz;
    #1;
    check(tag, observed(), expected(lh, rd, bz));
    @(posedge clk);
    model_update(lh, rd, bz);
  endtask

  // Asserts reset at a falling edge, checks INIT outputs for n cycles,
  // then releases between a rising edge and the next sampling point.
  task automatic apply_reset(input string tag, input int n);
    @(negedge clk);
    rst             = 1'b1;
    bus.load_hazard = 1'b0;
    bus.redirect    = 1'b0;
    bus.dmem_busy   = 1'b0;
    m_init = 1'b1; m_pend = 1'b0; m_bubble = 1'b0; m_run = 0; m_to = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check(tag, observed(), expected(1'b0, 1'b0, 1'b0));
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    bit lh, rd, bz;
    rst             = 1'b1;
    bus.load_hazard = 1'b0;
    bus.redirect    = 1'b0;
    bus.dmem_busy   = 1'b0;

    apply_reset("reset_hold", 3);
    step("init_cycle", 0, 0, 0);
    step("run_idle", 0, 0, 0);

    step("load_stall", 1, 0, 0);
    step("load_bubble", 1, 0, 0);
    step("after_bubble", 0, 0, 0);

    step("redir_vs_load", 1, 1, 0);
    step("redir_stays_run", 1, 0, 0);
    step("redir_bubble", 0, 0, 0);

    step("busy_c1", 0, 0, 1);
    for (int i = 0; i < 3; i++) step("busy_redir", 0, 1, 1);
    step("busy_replay", 0, 0, 0);
    step("busy2_c1", 0, 0, 1);
    step("busy2_c2", 0, 0, 1);
    step("pend_cleared", 0, 0, 0);

    step("busy_exit_c1", 0, 0, 1);
    step("busy_exit_load", 1, 0, 0);
    step("exit_bubble", 1, 0, 0);

    for (int i = 0; i < 17; i++) step("tmo_busy", 0, 0, 1);
    for (int i = 0; i < 3; i++) step("tmo_sticky", 0, 0, 0);

    step("rst_mid_c1", 0, 1, 1);
    step("rst_mid_c2", 0, 0, 1);
    apply_reset("rst_mid", 2);
    step("rst_mid_init", 0, 0, 0);
    step("rst_mid_noredir", 0, 0, 0);

    bz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        apply_reset("rand_rst", 1 + $urandom_range(0, 1));
        bz = 1'b0;
      end
      bz = bz ? ($urandom_range(0, 99) < 88) : ($urandom_range(0, 99) < 15);
      rd = ($urandom_range(0, 99) < 20);
      lh = ($urandom_range(0, 99) < 35);
      step("random", lh, rd, bz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
